// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC per-shot sequencer.
package tdc_pkg;

  localparam int unsigned SHOT_W      = 8;
  localparam int unsigned GAP_W       = 12;
  localparam int unsigned START_W_DEF = 4;
  localparam int unsigned TO_CYC_DEF  = 4095;

  typedef enum logic [5:0] {
    StIdle    = 6'b000001,
    StFire    = 6'b000010,
    StWaitInt = 6'b000100,
    StWaitClr = 6'b001000,
    StHoldoff = 6'b010000,
    StDone    = 6'b100000
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tdc_wdog.sv
// Loadable down-counter that saturates at zero; done_o flags the terminal count.
module tdc_wdog #(
  parameter int unsigned W = 12
) (
  input  logic         clk5,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/tdc_shot_ctrl.sv
// Per-shot sequencer: fires TDC_start, waits for the TDC_INT set/clear cycle, holds off,
// and repeats for the captured number of shots per frame.
module tdc_shot_ctrl import tdc_pkg::*; #(
  parameter int unsigned START_W = START_W_DEF,
  parameter int unsigned TO_CYC  = TO_CYC_DEF
) (
  input  logic              clk5,
  input  logic              rst_n,
  input  logic              frame_start_i,
  input  logic              abort_i,
  input  logic [SHOT_W-1:0] cfg_shots_i,
  input  logic [GAP_W-1:0]  cfg_gap_i,
  input  logic              tdc_int_i,
  output logic              tdc_start_o,
  output logic [SHOT_W-1:0] shot_idx_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              timeout_err_o
);

  localparam int unsigned WcntW = max_u(GAP_W, $clog2(TO_CYC + 1));
  localparam logic [WcntW-1:0] StartVal   = WcntW'(START_W - 1);
  localparam logic [WcntW-1:0] TimeoutVal = WcntW'(TO_CYC - 1);

  state_e            state_q;
  logic [SHOT_W-1:0] shots_q, shot_idx_q;
  logic [GAP_W-1:0]  gap_q;
  logic              tdc_start_q, busy_q, frame_done_q, timeout_err_q;

  logic              wd_load, wd_done, last_shot;
  logic [WcntW-1:0]  wd_val, hold_val;

  assign last_shot = (shot_idx_q == shots_q - 1'b1);
  // A zero gap still spends one cycle in HOLDOFF.
  assign hold_val  = (gap_q == '0) ? '0 : WcntW'(gap_q - 1'b1);

  // One shared counter times the start pulse, both watchdog waits and the hold-off.
  always_comb begin
    wd_load = 1'b0;
    wd_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (frame_start_i && (cfg_shots_i != '0)) begin
          wd_load = 1'b1;
          wd_val  = StartVal;
        end
      end
      StFire: begin
        if (wd_done) begin
          wd_load = 1'b1;
          wd_val  = TimeoutVal;
        end
      end
      StWaitInt: begin
        if (tdc_int_i) begin
          wd_load = 1'b1;
          wd_val  = TimeoutVal;
        end else if (wd_done) begin
          wd_load = 1'b1;
          wd_val  = hold_val;
        end
      end
      StWaitClr: begin
        if (!tdc_int_i || wd_done) begin
          wd_load = 1'b1;
          wd_val  = hold_val;
        end
      end
      StHoldoff: begin
        if (wd_done && !last_shot) begin
          wd_load = 1'b1;
          wd_val  = StartVal;
        end
      end
      default: ;
    endcase
  end

  tdc_wdog #(
    .W (WcntW)
  ) u_wdog (
    .clk5       (clk5),
    .rst_n      (rst_n),
    .load_i     (wd_load),
    .load_val_i (wd_val),
    .done_o     (wd_done)
  );

  always_ff @(posedge clk5 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      shots_q       <= '0;
      gap_q         <= '0;
      shot_idx_q    <= '0;
      tdc_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (abort_i) begin
        state_q     <= StIdle;
        tdc_start_q <= 1'b0;
        busy_q      <= 1'b0;
        shot_idx_q  <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (frame_start_i) begin
              timeout_err_q <= 1'b0;
              if (cfg_shots_i != '0) begin
                shots_q     <= cfg_shots_i;
                gap_q       <= cfg_gap_i;
                shot_idx_q  <= '0;
                tdc_start_q <= 1'b1;
                busy_q      <= 1'b1;
                state_q     <= StFire;
              end else begin
                frame_done_q <= 1'b1;
              end
            end
          end
          StFire: begin
            if (wd_done) begin
              tdc_start_q <= 1'b0;
              state_q     <= StWaitInt;
            end
          end
          StWaitInt: begin
            if (tdc_int_i) begin
              state_q <= StWaitClr;
            end else if (wd_done) begin
              timeout_err_q <= 1'b1;
              state_q       <= StHoldoff;
            end
          end
          StWaitClr: begin
            if (!tdc_int_i) begin
              state_q <= StHoldoff;
            end else if (wd_done) begin
              timeout_err_q <= 1'b1;
              state_q       <= StHoldoff;
            end
          end
          StHoldoff: begin
            if (wd_done) begin
              if (last_shot) begin
                frame_done_q <= 1'b1;
                state_q      <= StDone;
              end else begin
                shot_idx_q  <= shot_idx_q + 1'b1;
                tdc_start_q <= 1'b1;
                state_q     <= StFire;
              end
            end
          end
          StDone: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: begin
            tdc_start_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        endcase
      end
    end
  end

  assign tdc_start_o   = tdc_start_q;
  assign shot_idx_o    = shot_idx_q;
  assign busy_o        = busy_q;
  assign frame_done_o  = frame_done_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_tdc_shot_ctrl.sv
// Self-checking bench for tdc_shot_ctrl: frame vectors from a table, a TDC_INT responder,
// and a scoreboard of expected start/done event cycles.
module tb_tdc_shot_ctrl;

  localparam int ST       = 4;
  localparam int TO       = 4095;
  localparam int NEVER    = 1_000_000;
  localparam int EV_START = 0;
  localparam int EV_DONE  = 1;

  logic       clk5 = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cfg_shots = '0;
  logic [11:0] cfg_gap = '0;
  logic       tdc_int = 1'b0;
  logic       tdc_start, busy, frame_done, timeout_err;
  logic [7:0] shot_idx;

  always #5 clk5 = ~clk5;

  tdc_shot_ctrl dut (
    .clk5          (clk5),
    .rst_n         (rst_n),
    .frame_start_i (frame_start),
    .abort_i       (abort),
    .cfg_shots_i   (cfg_shots),
    .cfg_gap_i     (cfg_gap),
    .tdc_int_i     (tdc_int),
    .tdc_start_o   (tdc_start),
    .shot_idx_o    (shot_idx),
    .busy_o        (busy),
    .frame_done_o  (frame_done),
    .timeout_err_o (timeout_err)
  );

  typedef struct { int kind; int idx; int cyc; } ev_t;
  typedef struct { int shots; int gap; int d; int c; int refs_at; bit exp_to; } vec_t;

  ev_t  q[$];
  vec_t tbl[7];

  int   n_chk = 0, n_fail = 0, cyc = 0;
  int   resp_d = NEVER, resp_c = 0, rk = 2 * NEVER;
  int   rise_cyc = 0, exp_to_cyc = -1;
  bit   rise_valid = 1'b0;
  logic start_prev = 1'b0, done_prev = 1'b0, to_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Rise-to-rise shot period (also last rise to frame_done) for a responder that raises
  // TDC_INT d cycles after the start edge and drops it c cycles later.
  function automatic int period(input int d, input int c, input int g);
    int a, b, h;
    h = (g == 0) ? 1 : g;
    if (d >= NEVER) begin
      b = ST + TO;
    end else begin
      a = (d + 1 > ST + 1) ? d + 1 : ST + 1;
      b = (a + 1 > d + 1 + c) ? a + 1 : d + 1 + c;
    end
    return b + h;
  endfunction

  // One clock: observe outputs at the falling edge, run the responder, return 1 after posedge.
  task automatic tick();
    ev_t e;
    @(negedge clk5);
    cyc++;
    if (tdc_start && !start_prev) begin
      check("start_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("start_kind", e.kind, EV_START);
        check("start_cycle", cyc, e.cyc);
        check("start_shot_idx", int'(shot_idx), e.idx);
      end
      rise_cyc   = cyc;
      rise_valid = 1'b1;
    end
    if (!tdc_start && start_prev && rise_valid) begin
      check("start_width", cyc - rise_cyc, ST);
      rise_valid = 1'b0;
    end
    if (frame_done) begin
      check("done_single_cycle", int'(done_prev), 0);
      check("done_expected", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("done_kind", e.kind, EV_DONE);
        check("done_cycle", cyc, e.cyc);
      end
    end
    if (timeout_err && !to_prev) check("timeout_cycle", cyc, exp_to_cyc);
    if (tdc_start && !start_prev) rk = 0;
    else if (rk < 2 * NEVER) rk++;
    if (rk == resp_d) tdc_int = 1'b1;
    if (rk == resp_d + resp_c) tdc_int = 1'b0;
    start_prev = tdc_start;
    done_prev  = frame_done;
    to_prev    = timeout_err;
    @(posedge clk5);
    #1;
  endtask

  task automatic run_frame(input vec_t v);
    int t, j, lim, p;
    bit busy_seen;
    resp_d    = v.d;
    resp_c    = v.c;
    cfg_shots = 8'(v.shots);
    cfg_gap   = 12'(v.gap);
    p = period(v.d, v.c, v.gap);
    t = cyc + 2;
    exp_to_cyc = v.exp_to ? t + ST + TO : -1;
    for (int i = 0; i < v.shots; i++) begin
      q.push_back('{EV_START, i, t});
      t += p;
    end
    q.push_back('{EV_DONE, 0, t});
    lim = t - cyc + 20;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    busy_seen = busy;
    j = 1;
    while (q.size() > 0 && j < lim) begin
      if (j == v.refs_at) begin
        frame_start = 1'b1;
        cfg_shots   = 8'd7;
        cfg_gap     = 12'd0;
      end
      tick();
      j++;
      frame_start = 1'b0;
      cfg_shots   = 8'(v.shots);
      cfg_gap     = 12'(v.gap);
      if (busy) busy_seen = 1'b1;
    end
    check("frame_events_drained", q.size(), 0);
    q.delete();
    repeat (3) tick();
    check("busy_idle_after_frame", int'(busy), 0);
    check("busy_seen", int'(busy_seen), int'(v.shots != 0));
    check("timeout_err", int'(timeout_err), int'(v.exp_to));
    if (v.shots != 0) check("last_shot_idx", int'(shot_idx), v.shots - 1);
  endtask

  initial begin
    int t, j;
    tbl[0] = '{3, 10, 20, 8, -1, 1'b0};
    tbl[1] = '{0, 5, 20, 8, -1, 1'b0};
    tbl[2] = '{1, 0, 1, 6, -1, 1'b0};
    tbl[3] = '{2, 1, 4, 2, -1, 1'b0};
    tbl[4] = '{2, 5, NEVER, 0, -1, 1'b1};
    tbl[5] = '{5, 3, 10, 1, -1, 1'b0};
    tbl[6] = '{3, 10, 20, 8, 33, 1'b0};

    #1 rst_n = 1'b0;
    #2;
    check("rst_tdc_start", int'(tdc_start), 0);
    check("rst_shot_idx", int'(shot_idx), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    repeat (2) @(posedge clk5);
    #1 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_frame(tbl[i]);

    // abort and frame_start together: abort wins, nothing starts
    cfg_shots   = 8'd2;
    cfg_gap     = 12'd0;
    resp_d      = NEVER;
    frame_start = 1'b1;
    abort       = 1'b1;
    tick();
    frame_start = 1'b0;
    abort       = 1'b0;
    check("abort_vs_start_busy", int'(busy), 0);
    repeat (8) tick();
    check("abort_vs_start_tdc_start", int'(tdc_start), 0);

    // abort during WAIT_CLR of shot 1 of 4
    resp_d    = 20;
    resp_c    = 8;
    cfg_shots = 8'd4;
    cfg_gap   = 12'd2;
    t = cyc + 2;
    exp_to_cyc = -1;
    q.push_back('{EV_START, 0, t});
    q.push_back('{EV_START, 1, t + period(20, 8, 2)});
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    j = 0;
    while (q.size() > 0 && j < 200) begin
      tick();
      j++;
    end
    check("abort_pre_drained", q.size(), 0);
    q.delete();
    repeat (22) tick();
    check("abort_pre_busy", int'(busy), 1);
    check("abort_pre_shot_idx", int'(shot_idx), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_tdc_start", int'(tdc_start), 0);
    check("abort_shot_idx", int'(shot_idx), 0);
    check("abort_timeout_err", int'(timeout_err), 0);
    repeat (60) tick();
    run_frame(tbl[0]);

    // reset during FIRE of the second shot of a timed-out frame
    resp_d    = NEVER;
    resp_c    = 0;
    cfg_shots = 8'd2;
    cfg_gap   = 12'd5;
    t = cyc + 2;
    exp_to_cyc = t + ST + TO;
    q.push_back('{EV_START, 0, t});
    q.push_back('{EV_START, 1, t + period(NEVER, 0, 5)});
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    j = 0;
    while (q.size() > 0 && j < 5000) begin
      tick();
      j++;
    end
    check("rst_pre_drained", q.size(), 0);
    check("rst_pre_tdc_start", int'(tdc_start), 1);
    check("rst_pre_timeout_err", int'(timeout_err), 1);
    rst_n = 1'b0;
    #1;
    check("rst_fire_tdc_start", int'(tdc_start), 0);
    check("rst_fire_shot_idx", int'(shot_idx), 0);
    check("rst_fire_busy", int'(busy), 0);
    check("rst_fire_frame_done", int'(frame_done), 0);
    check("rst_fire_timeout_err", int'(timeout_err), 0);
    q.delete();
    rise_valid = 1'b0;
    exp_to_cyc = -1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_tdc_start", int'(tdc_start), 0);
    run_frame(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete, got cycle %0d", cyc);
    $fatal(1);
  end

endmodule
